// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle execution FSM for the Mini-MIPS core. Takes the decoded
// per-instruction control flags, latches them in DECODE, and walks each
// instruction through FETCH / DECODE / EXEC / MULT / MEM / WB. It also drives
// the PC/IR strobes, the register-file strobes, the data-memory strobes and the
// iterative multiplier handshake.
//
// Parameters:
//   MULT_CYCLES  cycles spent in MULT (>= 1)
//   MEM_TIMEOUT  MEM cycles without mem_ready before mem_err is raised (>= 1)
//   CNT_W        width of the performance counters
//
// Optional feature macro: PERF_COUNT_EN
//   defined   : cycle_count / retired_count are live counters
//   undefined : both ports are tied to zero and no counter is built
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   halt_req, run      stop after current instruction / leave IDLE
//   dec_*              decoded instruction flags (sampled in DECODE only)
//   alu_zero           ALU zero flag (used in EXEC)
//   mem_ready          data-memory completion
//   state, busy        current state, state != IDLE
//   ir_write, pc_write, pc_src        fetch / PC control
//   reg_write, fp_reg_write, mem_to_reg register-file writeback control
//   mem_rd_en, mem_wr_en              data-memory strobes
//   mult_start, hilo_write            multiplier control
//   instr_done         one-cycle retire pulse
//   mem_err            sticky memory timeout flag
//   cycle_count, retired_count        performance counters
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
   parameter int MULT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halt_req,
   input  logic             run,
   input  logic             dec_regwrite,
   input  logic             dec_fpregwrite,
   input  logic             dec_memread,
   input  logic             dec_memwrite,
   input  logic             dec_jump,
   input  logic             dec_jal,
   input  logic             dec_jr,
   input  logic             dec_branch,
   input  logic             dec_bne,
   input  logic             dec_mult,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic [2:0]       state,
   output logic             busy,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic             fp_reg_write,
   output logic             mem_to_reg,
   output logic             mem_rd_en,
   output logic             mem_wr_en,
   output logic             mult_start,
   output logic             hilo_write,
   output logic             instr_done,
   output logic             mem_err,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retired_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MULT   = 3'd4;
   localparam logic [2:0] S_MEM    = 3'd5;
   localparam logic [2:0] S_WB     = 3'd6;

   localparam int MC_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
   localparam int MT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   typedef struct packed {
      logic regwrite;
      logic fpregwrite;
      logic memread;
      logic memwrite;
      logic jump;
      logic jal;
      logic jr;
      logic branch;
      logic bne;
      logic mult;
   } flags_t;

   logic [2:0]      state_r;
   logic [2:0]      next_state_s;
   logic            done_s;
   flags_t          flags_r;
   flags_t          dec_flags_s;
   logic [MC_W-1:0] mult_cnt_r;
   logic            mult_first_r;
   logic [MT_W-1:0] mem_cnt_r;
   logic            mem_err_r;

   logic            jump_class_s;
   logic            branch_class_s;
   logic            mem_op_s;
   logic            wb_op_s;
   logic            mult_last_s;
   logic            mem_timeout_s;
   logic [2:0]      complete_next_s;

   assign dec_flags_s = '{regwrite:   dec_regwrite,
                          fpregwrite: dec_fpregwrite,
                          memread:    dec_memread,
                          memwrite:   dec_memwrite,
                          jump:       dec_jump,
                          jal:        dec_jal,
                          jr:         dec_jr,
                          branch:     dec_branch,
                          bne:        dec_bne,
                          mult:       dec_mult};

   assign jump_class_s    = flags_r.jump | flags_r.jal | flags_r.jr;
   assign branch_class_s  = flags_r.branch | flags_r.bne;
   assign mem_op_s        = flags_r.memread | flags_r.memwrite;
   assign wb_op_s         = flags_r.regwrite | flags_r.fpregwrite;
   assign mult_last_s     = (mult_cnt_r == {MC_W{1'b0}});
   assign mem_timeout_s   = (mem_cnt_r == MT_W'(MEM_TIMEOUT - 1));
   // A retiring instruction either parks in IDLE (halt requested) or fetches on.
   assign complete_next_s = halt_req ? S_IDLE : S_FETCH;

   assign state   = state_r;
   assign busy    = (state_r != S_IDLE);
   assign mem_err = mem_err_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and completion decode.
   always_comb begin
      next_state_s = state_r;
      done_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            // A latched memory error locks the sequencer until reset.
            if (run && !mem_err_r) begin
               next_state_s = S_FETCH;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_FETCH:  next_state_s = S_DECODE;
         S_DECODE: next_state_s = S_EXEC;
         S_EXEC: begin
            if (jump_class_s || branch_class_s) begin
               done_s       = 1'b1;
               next_state_s = complete_next_s;
            end else if (flags_r.mult) begin
               next_state_s = S_MULT;
            end else if (mem_op_s) begin
               next_state_s = S_MEM;
            end else if (wb_op_s) begin
               next_state_s = S_WB;
            end else begin
               done_s       = 1'b1;
               next_state_s = complete_next_s;
            end
         end
         S_MULT: begin
            if (mult_last_s) begin
               done_s       = 1'b1;
               next_state_s = complete_next_s;
            end else begin
               next_state_s = S_MULT;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               if (flags_r.memread) begin
                  next_state_s = S_WB;
               end else begin
                  done_s       = 1'b1;
                  next_state_s = complete_next_s;
               end
            end else if (mem_timeout_s) begin
               // Abandon the access: no retire pulse.
               next_state_s = S_IDLE;
            end else begin
               next_state_s = S_MEM;
            end
         end
         S_WB: begin
            done_s       = 1'b1;
            next_state_s = complete_next_s;
         end
         default: next_state_s = S_IDLE;
      endcase
   end

   // Output decode from state, latched flags and the handshake inputs.
   always_comb begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      reg_write    = 1'b0;
      fp_reg_write = 1'b0;
      mem_to_reg   = 1'b0;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      mult_start   = 1'b0;
      hilo_write   = 1'b0;
      instr_done   = done_s;
      case (state_r)
         S_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'b00;
         end
         S_EXEC: begin
            if (jump_class_s) begin
               pc_write  = 1'b1;
               pc_src    = (flags_r.jump || flags_r.jal) ? 2'b01 : 2'b10;
               reg_write = flags_r.jal;
            end else if (branch_class_s) begin
               pc_src   = 2'b11;
               pc_write = (flags_r.branch & alu_zero) | (flags_r.bne & ~alu_zero);
            end else begin
               pc_write = 1'b0;
            end
         end
         S_MULT: begin
            mult_start = mult_first_r;
            hilo_write = mult_last_s;
         end
         S_MEM: begin
            // Read wins; the write strobe is never raised alongside it.
            mem_rd_en  = flags_r.memread;
            mem_wr_en  = flags_r.memwrite & ~flags_r.memread;
            mem_to_reg = flags_r.memread;
         end
         S_WB: begin
            reg_write    = flags_r.regwrite;
            fp_reg_write = flags_r.fpregwrite;
            mem_to_reg   = flags_r.memread;
         end
         default: begin
            ir_write = 1'b0;
         end
      endcase
   end

   // Capture the decoded flags once per instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_r <= '0;
      end else if (state_r == S_DECODE) begin
         flags_r <= dec_flags_s;
      end else begin
         flags_r <= flags_r;
      end
   end

   // Multiplier cycle counter: loaded on MULT entry, counts down to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         mult_cnt_r   <= {MC_W{1'b0}};
         mult_first_r <= 1'b0;
      end else if (state_r == S_EXEC && next_state_s == S_MULT) begin
         mult_cnt_r   <= MC_W'(MULT_CYCLES - 1);
         mult_first_r <= 1'b1;
      end else if (state_r == S_MULT) begin
         mult_first_r <= 1'b0;
         if (!mult_last_s) begin
            mult_cnt_r <= mult_cnt_r - MC_W'(1);
         end else begin
            mult_cnt_r <= mult_cnt_r;
         end
      end else begin
         mult_cnt_r   <= mult_cnt_r;
         mult_first_r <= 1'b0;
      end
   end

   // MEM wait counter: counts cycles spent waiting, cleared outside MEM.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_cnt_r <= {MT_W{1'b0}};
      end else if (state_r == S_MEM) begin
         mem_cnt_r <= mem_cnt_r + MT_W'(1);
      end else begin
         mem_cnt_r <= {MT_W{1'b0}};
      end
   end

   // Sticky memory timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_err_r <= 1'b0;
      end else if (state_r == S_MEM && !mem_ready && mem_timeout_s) begin
         mem_err_r <= 1'b1;
      end else begin
         mem_err_r <= mem_err_r;
      end
   end

`ifdef PERF_COUNT_EN
   logic [CNT_W-1:0] cycle_cnt_r;
   logic [CNT_W-1:0] retired_cnt_r;

   // Busy-cycle and retired-instruction counters, wrapping naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_r   <= {CNT_W{1'b0}};
         retired_cnt_r <= {CNT_W{1'b0}};
      end else begin
         cycle_cnt_r   <= busy   ? (cycle_cnt_r + CNT_W'(1))   : cycle_cnt_r;
         retired_cnt_r <= done_s ? (retired_cnt_r + CNT_W'(1)) : retired_cnt_r;
      end
   end

   assign cycle_count   = cycle_cnt_r;
   assign retired_count = retired_cnt_r;
`else
   assign cycle_count   = {CNT_W{1'b0}};
   assign retired_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed-vector bench for multicycle_sequencer (MULT_CYCLES=4,
// MEM_TIMEOUT=16). Each instruction is run from FETCH to retirement while
// strobe activity is recorded per cycle; the recorded values are then compared
// with hand-computed expectations. Counter expectations follow PERF_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

   localparam int CNT_W = 32;
`ifdef PERF_COUNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // flag vector order: {regwrite, fpregwrite, memread, memwrite, jump, jal, jr, branch, bne, mult}
   localparam logic [9:0] F_ADD  = 10'b1000000000;
   localparam logic [9:0] F_LW   = 10'b1010000000;
   localparam logic [9:0] F_SW   = 10'b0001000000;
   localparam logic [9:0] F_JAL  = 10'b0000010000;
   localparam logic [9:0] F_JR   = 10'b0000001000;
   localparam logic [9:0] F_BEQ  = 10'b0000000100;
   localparam logic [9:0] F_BNE  = 10'b0000000010;
   localparam logic [9:0] F_MULT = 10'b0000000001;

   logic clk = 1'b0;
   logic rst, halt_req, run;
   logic dec_regwrite, dec_fpregwrite, dec_memread, dec_memwrite;
   logic dec_jump, dec_jal, dec_jr, dec_branch, dec_bne, dec_mult;
   logic alu_zero, mem_ready;
   logic [2:0] state;
   logic busy, ir_write, pc_write, reg_write, fp_reg_write, mem_to_reg;
   logic [1:0] pc_src;
   logic mem_rd_en, mem_wr_en, mult_start, hilo_write, instr_done, mem_err;
   logic [CNT_W-1:0] cycle_count, retired_count;

   int vec_cnt = 0;
   int err_cnt = 0;

   // per-instruction record
   int         done_cyc, n_regw, regw_cyc, n_rd, n_wr, n_both, n_ms, ms_cyc, n_hl, hl_cyc, err_cyc;
   logic       ex_pcw, m2r_wb;
   logic [1:0] ex_pcsrc;
   logic [2:0] after_state;
   logic [2:0] st_tr [1:32];

   multicycle_sequencer #(.MULT_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .halt_req(halt_req), .run(run),
      .dec_regwrite(dec_regwrite), .dec_fpregwrite(dec_fpregwrite),
      .dec_memread(dec_memread), .dec_memwrite(dec_memwrite),
      .dec_jump(dec_jump), .dec_jal(dec_jal), .dec_jr(dec_jr),
      .dec_branch(dec_branch), .dec_bne(dec_bne), .dec_mult(dec_mult),
      .alu_zero(alu_zero), .mem_ready(mem_ready),
      .state(state), .busy(busy), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .reg_write(reg_write), .fp_reg_write(fp_reg_write),
      .mem_to_reg(mem_to_reg), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mult_start(mult_start), .hilo_write(hilo_write), .instr_done(instr_done),
      .mem_err(mem_err), .cycle_count(cycle_count), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint got, input longint exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_flags(input logic [9:0] f);
      {dec_regwrite, dec_fpregwrite, dec_memread, dec_memwrite, dec_jump,
       dec_jal, dec_jr, dec_branch, dec_bne, dec_mult} = f;
   endtask

   // Entered at posedge+1 with the DUT in FETCH. rdy_cyc is the cycle index
   // (FETCH = 1) in which mem_ready is raised, 0 for never.
   task automatic run_instr(input logic [9:0] f, input logic az, input int rdy_cyc,
                            input logic hlt, input int budget);
      done_cyc = 0; n_regw = 0; regw_cyc = 0; n_rd = 0; n_wr = 0; n_both = 0;
      n_ms = 0; ms_cyc = 0; n_hl = 0; hl_cyc = 0; err_cyc = 0;
      ex_pcw = 1'b0; ex_pcsrc = 2'b00; m2r_wb = 1'b0;
      for (int i = 1; i <= 32; i++) st_tr[i] = 3'd7;
      set_flags(f);
      alu_zero = az;
      halt_req = hlt;
      for (int c = 1; c <= budget; c++) begin
         mem_ready = (c == rdy_cyc);
         #1;
         if (c <= 32) st_tr[c] = state;
         if (reg_write) begin n_regw++; regw_cyc = c; end
         if (mem_rd_en) n_rd++;
         if (mem_wr_en) n_wr++;
         if (mem_rd_en && mem_wr_en) n_both++;
         if (mult_start) begin n_ms++; ms_cyc = c; end
         if (hilo_write) begin n_hl++; hl_cyc = c; end
         if (mem_err && err_cyc == 0) err_cyc = c;
         if (c == 3) begin ex_pcw = pc_write; ex_pcsrc = pc_src; end
         if (reg_write && mem_to_reg) m2r_wb = 1'b1;
         if (instr_done) done_cyc = c;
         @(posedge clk);
         #1;
         if (done_cyc != 0) break;
      end
      mem_ready = 1'b0;
      #1;
      after_state = state;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; halt_req = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0;
      set_flags(10'b0);
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_state", state, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_strobes", {ir_write, pc_write, reg_write, mem_rd_en, mem_wr_en, mult_start, instr_done}, 0);
      check_val("rst_mem_err", mem_err, 0);
      check_val("rst_cycle_count", cycle_count, 0);

      rst = 1'b0; run = 1'b1;
      @(posedge clk); #1;
      check_val("run_to_fetch", state, 1);
      check_val("fetch_strobes", {ir_write, pc_write, pc_src}, 4'b1100);

      // add: FETCH, DECODE, EXEC, WB
      run_instr(F_ADD, 1'b0, 0, 1'b0, 20);
      check_val("add_trace", {st_tr[1], st_tr[2], st_tr[3], st_tr[4]}, {3'd1, 3'd2, 3'd3, 3'd6});
      check_val("add_done", done_cyc, 4);
      check_val("add_regw_cnt", n_regw, 1);
      check_val("add_regw_cyc", regw_cyc, 4);
      check_val("add_next", after_state, 1);

      // beq taken
      run_instr(F_BEQ, 1'b1, 0, 1'b0, 20);
      check_val("beq_pcw", ex_pcw, 1);
      check_val("beq_pcsrc", ex_pcsrc, 3);
      check_val("beq_done", done_cyc, 3);
      check_val("retired_after_2", retired_count, PERF ? 2 : 0);

      // bne with zero: not taken
      run_instr(F_BNE, 1'b1, 0, 1'b0, 20);
      check_val("bne_pcw", ex_pcw, 0);
      check_val("bne_pcsrc", ex_pcsrc, 3);
      check_val("bne_done", done_cyc, 3);

      // lw, ready in third MEM cycle (cycle 6)
      run_instr(F_LW, 1'b0, 6, 1'b0, 30);
      check_val("lw_rd_cycles", n_rd, 3);
      check_val("lw_wr_cycles", n_wr, 0);
      check_val("lw_done", done_cyc, 7);
      check_val("lw_regw_cyc", regw_cyc, 7);
      check_val("lw_mem_to_reg", m2r_wb, 1);

      // sw, ready in first MEM cycle
      run_instr(F_SW, 1'b0, 4, 1'b0, 30);
      check_val("sw_wr_cycles", n_wr, 1);
      check_val("sw_rd_cycles", n_rd, 0);
      check_val("sw_done", done_cyc, 4);
      check_val("sw_regw", n_regw, 0);

      // mult with MULT_CYCLES=4
      run_instr(F_MULT, 1'b0, 0, 1'b0, 30);
      check_val("mult_start_cnt", n_ms, 1);
      check_val("mult_start_cyc", ms_cyc, 4);
      check_val("hilo_cnt", n_hl, 1);
      check_val("hilo_cyc", hl_cyc, 7);
      check_val("mult_done", done_cyc, 7);

      // jr
      run_instr(F_JR, 1'b0, 0, 1'b0, 20);
      check_val("jr_pcw", ex_pcw, 1);
      check_val("jr_pcsrc", ex_pcsrc, 2);
      check_val("jr_regw", n_regw, 0);
      check_val("jr_done", done_cyc, 3);

      // jal with halt: link write, then IDLE
      run_instr(F_JAL, 1'b0, 0, 1'b1, 20);
      check_val("jal_pcw", ex_pcw, 1);
      check_val("jal_pcsrc", ex_pcsrc, 1);
      check_val("jal_regw_cyc", regw_cyc, 3);
      check_val("jal_done", done_cyc, 3);
      check_val("jal_halt_idle", after_state, 0);
      check_val("cycle_count", cycle_count, PERF ? 34 : 0);
      check_val("retired_count", retired_count, PERF ? 8 : 0);
      run = 1'b0; halt_req = 1'b0;
      @(posedge clk); #1;
      check_val("idle_hold", state, 0);

      // lw that never gets mem_ready: timeout after 16 MEM cycles
      run = 1'b1;
      @(posedge clk); #1;
      run_instr(F_LW, 1'b0, 0, 1'b0, 30);
      check_val("to_done", done_cyc, 0);
      check_val("to_rd_cycles", n_rd, 16);
      check_val("to_last_mem", st_tr[19], 5);
      check_val("to_idle", st_tr[20], 0);
      check_val("to_err_cyc", err_cyc, 20);
      check_val("to_run_ignored", st_tr[30], 0);
      check_val("to_mem_err", mem_err, 1);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; run = 1'b0;
      check_val("err_cleared", mem_err, 0);

      // reset in the middle of WB
      run = 1'b1; set_flags(F_ADD);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;
      check_val("midwb_state", state, 6);
      check_val("midwb_regw", reg_write, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("after_rst_regw", reg_write, 0);
      check_val("after_rst_state", state, 0);
      check_val("after_rst_retired", retired_count, 0);
      check_val("after_rst_cycles", cycle_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle execution FSM for the Mini-MIPS core.
- Takes the decoded per-instruction control flags from the instruction decoder and sequences fetch, decode, execute, multiply, memory and writeback across several cycles.
- Drives the PC/IR write enables, memory strobes and register-file write strobes, and arbitrates the iterative multiplier and the data-memory handshake.

Parameters:
- MULT_CYCLES, 4, cycles spent in MULT state (min 1)
- MEM_TIMEOUT, 16, cycles MEM waits for mem_ready before flagging an error (min 1)
- CNT_W, 32, width of performance counters (optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- halt_req  in  1  stop after the current instruction completes
- run  in  1  leave IDLE and start fetching
- dec_regwrite, dec_fpregwrite, dec_memread, dec_memwrite  in  1 each  decoded flags
- dec_jump, dec_jal, dec_jr, dec_branch, dec_bne, dec_mult  in  1 each  decoded flags
- alu_zero  in  1  integer ALU zero flag, valid in EXEC
- mem_ready  in  1  data-memory completion
- state  out  3  current state
- busy  out  1  state != IDLE
- ir_write  out  1  latch instruction register
- pc_write  out  1  PC update strobe
- pc_src  out  2  00 PC+4, 01 jump target, 10 register (jr), 11 branch target
- reg_write  out  1  integer regfile write
- fp_reg_write  out  1  FP regfile write
- mem_to_reg  out  1  writeback source is memory
- mem_rd_en  out  1  data-memory read strobe
- mem_wr_en  out  1  data-memory write strobe
- mult_start  out  1  multiplier start pulse
- hilo_write  out  1  HI/LO write pulse
- instr_done  out  1  one-cycle retire pulse
- mem_err  out  1  sticky memory timeout flag
- cycle_count  out  CNT_W  busy cycles (optional feature)
- retired_count  out  CNT_W  retired instructions (optional feature)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - state = IDLE; all strobes, mem_err and counters = 0.
  - Reset mid-instruction abandons it; no strobe is asserted in the cycle after reset.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MULT=4, MEM=5, WB=6; 7 is illegal and returns to IDLE.
- Outputs: combinational from state plus the flags latched in DECODE. The dec_* inputs are sampled only in DECODE and ignored elsewhere.
- IDLE: run=1 -> FETCH. run is ignored while mem_err=1.
- FETCH: ir_write=1, pc_write=1, pc_src=00 -> DECODE.
- DECODE: latch dec_* flags -> EXEC.
- EXEC: priority jump-class > branch > mult > mem > wb.
  - Jump-class:
    - jump/jal: pc_write=1, pc_src=01.
    - jr: pc_write=1, pc_src=10.
    - jal: reg_write=1 (link) in the same cycle.
    - Then instruction completes.
  - Branch: pc_src=11; pc_write = (branch & alu_zero) | (bne & ~alu_zero); then completes.
  - mult -> MULT.
  - memread or memwrite -> MEM.
  - regwrite or fpregwrite -> WB.
  - Otherwise: completes (nop).
- MULT:
  - mult_start=1 in first MULT cycle only; counter loaded with MULT_CYCLES-1.
  - hilo_write=1 in the cycle the counter reaches 0; then completes.
- MEM:
  - Hold mem_rd_en (memread) or mem_wr_en (memwrite only). memread has priority; mem_wr_en is never asserted with mem_rd_en.
  - mem_ready=1: read -> WB with mem_to_reg=1; write -> completes.
  - mem_ready in the first MEM cycle gives a one-cycle MEM.
  - MEM_TIMEOUT cycles without ready: mem_err=1 (sticky until rst), go to IDLE, no instr_done.
- WB: reg_write=latched regwrite, fp_reg_write=latched fpregwrite, mem_to_reg held as in MEM path, one cycle; then completes.
- Completion:
  - instr_done=1 in the completing cycle.
  - Next state = IDLE if halt_req=1 in that cycle, else FETCH.
- Latencies (cycles, FETCH through completion):
  - R-type/FP: 4
  - jump/branch/nop: 3
  - lw: 4+n (n = MEM cycles)
  - sw: 3+n
  - mult: 3+MULT_CYCLES

Optional Feature:
- Macro: PERF_COUNT_EN.
- Defined:
  - cycle_count increments every cycle busy=1.
  - retired_count increments on instr_done.
  - Both wrap modulo 2^CNT_W and clear on rst.
- Undefined: ports remain present and tied to 0; no counter registers are inferred.

Test Plan:
- rst, run=1, add flags (regwrite) -> FETCH,DECODE,EXEC,WB; reg_write only in cycle 4; instr_done cycle 4; state back to FETCH.
- beq with alu_zero=1 -> pc_write=1, pc_src=11 in EXEC. bne with alu_zero=1 -> pc_write=0. instr_done after 3 cycles each.
- lw, mem_ready at 3rd MEM cycle -> mem_rd_en high 3 cycles, WB with mem_to_reg=1 and reg_write=1, total 7 cycles. sw with ready in 1st cycle -> total 4 cycles, mem_wr_en 1 cycle.
- mult, MULT_CYCLES=4 -> mult_start 1 cycle, hilo_write 4th MULT cycle, instr_done at cycle 7.
- MEM_TIMEOUT=16, mem_ready held 0 -> mem_err=1 after 16 MEM cycles, state=IDLE, run=1 ignored until rst.
- jal with halt_req=1 -> pc_write=1, pc_src=01, reg_write=1, instr_done, then IDLE. With PERF_COUNT_EN, after 2 instructions retired_count=2; rst mid-WB -> next cycle reg_write=0, counters=0.
